titan_lsu: RTL and testbench
============================

Name: titan_lsu

Overview:
- Load/store unit in the MEM stage, the consumer of the decoder's 6-bit mem_flags bundle {mem_wr, mem_r, word, hw, byte, unsigned}.
- Turns a flagged memory op into a single-beat data-bus transaction: byte-lane steering on stores, extraction plus sign/zero extension on loads.
- Detects misaligned accesses and bus faults, and stalls the pipeline until the access completes.

Parameters:
TIMEOUT_CYCLES, 256, BUSY cycles without ack/err before a fault is forced; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_valid  in  1  MEM stage holds a valid instruction
mem_flags  in  6  {wr, r, word, hw, byte, unsigned}
mem_addr  in  32  effective address from the ALU
mem_wdata  in  32  store data (rs2)
mem_kill  in  1  flush of the MEM-stage instruction
lsu_rdata  out  32  extended load result, valid with lsu_done
lsu_done  out  1  one-cycle completion pulse
lsu_stall  out  1  hold the pipeline
lsu_ld_misaligned  out  1  one-cycle pulse
lsu_st_misaligned  out  1  one-cycle pulse
lsu_ld_fault  out  1  one-cycle pulse
lsu_st_fault  out  1  one-cycle pulse
lsu_bad_addr  out  32  faulting address, valid with any exception pulse
dport_addr  out  32  word-aligned address ({mem_addr[31:2],2'b00})
dport_wdata  out  32  lane-replicated store data
dport_sel  out  4  byte enables
dport_we  out  1  write enable
dport_cyc  out  1  bus cycle
dport_stb  out  1  strobe
dport_rdata  in  32  read data
dport_ack  in  1  transfer complete
dport_err  in  1  bus error

Behaviour:
- Reset (async, rst=1): state IDLE, timeout counter 0, kill flag 0, every output 0. Reset during BUSY drops cyc/stb immediately.
- Valid op: mem_valid & ~mem_kill & (wr XOR r) & access bits one-hot. Any other flag combination is a no-op: no bus cycle, no pulses, no stall.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On a valid aligned op, lsu_stall=1 combinationally that cycle.
  - Next edge registers the dport_* fields, sets cyc=stb=1 and moves to BUSY.
- Misalignment: word with addr[1:0]!=0, or hw with addr[0]!=0.
  - No bus cycle and no stall.
  - Next cycle pulses the ld/st_misaligned bit matching the op, with lsu_bad_addr=mem_addr.
  - State stays IDLE. Flags re-evaluate only after the pipeline advances; the pulse fires once per op.
- Stores:
  - Byte: sel=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - Half-word: sel=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - Word: sel=4'b1111.
  - we=1.
- Loads: sel as for stores, we=0.
- BUSY:
  - lsu_stall=1.
  - All dport_* outputs stay stable until ack or err.
  - Counter increments every cycle.
- ack sampled:
  - cyc/stb drop at that edge, go to DONE.
  - Loads capture the data: byte = rdata[8*addr[1:0]+:8], half-word = rdata[16*addr[1]+:16], word = full.
  - Extension: sign when unsigned=0, zero otherwise.
- err sampled, or counter reaches TIMEOUT_CYCLES:
  - cyc/stb drop, go to DONE with the fault flag set.
  - ack and err in the same cycle: err wins.
  - ack in the same cycle the counter reaches the limit: ack wins.
- DONE (one cycle):
  - lsu_stall=0, lsu_done=1.
  - On success: lsu_rdata = extended load data (0 for stores).
  - On fault: ld/st_fault pulse, lsu_bad_addr=mem_addr, lsu_rdata=0.
  - Inputs are ignored. The next cycle returns to IDLE and evaluates the new MEM op.
  - Back-to-back ops have a minimum spacing of 3 cycles (accept, BUSY, DONE).
- mem_kill:
  - In IDLE it blocks acceptance.
  - In BUSY it sets a kill flag. The bus cycle still completes (never abandoned), stall stays high, and DONE emits no done/fault pulse.
  - The kill flag clears in DONE.
- Load-data capture, exception pulses and lsu_rdata are all registered. Only lsu_stall is combinational.

Test Plan:
- lw addr=0x1000, ack 2 cycles after stb, rdata=0xDEADBEEF -> dport_addr=0x1000, sel=1111, we=0; lsu_done 1 cycle after ack; lsu_rdata=0xDEADBEEF; stall high from accept to ack cycle.
- lb addr=0x2003, rdata=0x80FF_0000; repeat as lbu -> lsu_rdata=0xFFFFFF80 for lb, 0x00000080 for lbu; sel=1000.
- sh addr=0x3002, wdata=0x1234ABCD -> dport_wdata=0xABCDABCD, sel=1100, we=1; lsu_done pulses; lsu_rdata=0.
- lw addr=0x4001 -> no cyc, no stall; lsu_ld_misaligned pulses 1 cycle, lsu_bad_addr=0x4001.
- sw addr=0x5000 with err asserted together with ack -> lsu_st_fault=1, lsu_done=1, bad_addr=0x5000; separately, no ack with TIMEOUT_CYCLES=4 -> fault after 4 BUSY cycles.
- lw accepted, mem_kill asserted in first BUSY cycle, ack 3 cycles later -> cyc held until ack, no lsu_done/fault pulse; next lw processed normally. Async rst mid-BUSY -> cyc/stb/stall drop immediately.

Source files
------------

// File: rtl/titan_lsu_if.sv
// Single-beat data-bus port between the load/store unit (master) and data memory (slave).
interface titan_lsu_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output addr, wdata, sel, we, cyc, stb, input rdata, ack, err);
    modport slave  (input addr, wdata, sel, we, cyc, stb, output rdata, ack, err);
endinterface

// File: rtl/titan_lsu.sv
// MEM-stage load/store unit: turns decoded mem_flags into one data-bus beat, steering store
// lanes, extending load data, and reporting misalignment and bus faults.
module titan_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [5:0]  mem_flags,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_kill,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_stall,
    output logic        lsu_ld_misaligned,
    output logic        lsu_st_misaligned,
    output logic        lsu_ld_fault,
    output logic        lsu_st_fault,
    output logic [31:0] lsu_bad_addr,
    titan_lsu_if.master dport
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, addr_q, wdata_q, rdata_q, bad_addr_q;
    logic [3:0]  sel_q;
    logic        we_q, cyc_q, kill_q, word_q, hw_q, uns_q;
    logic        done_q, ld_mis_q, st_mis_q, ld_flt_q, st_flt_q;

    logic        f_wr, f_rd, f_word, f_hw, f_byte, f_uns;
    logic        op_ok, mis, accept, mis_ev, tmo, bus_end, fault, killed;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, ld_ext;
    logic [15:0] hw16;
    logic [7:0]  by8;

    assign {f_wr, f_rd, f_word, f_hw, f_byte, f_uns} = mem_flags;

    assign op_ok = mem_valid & ~mem_kill & (f_wr ^ f_rd) &
                   ((f_word & ~f_hw & ~f_byte) | (~f_word & f_hw & ~f_byte) |
                    (~f_word & ~f_hw & f_byte));
    assign mis    = (f_word & (mem_addr[1:0] != 2'b00)) | (f_hw & mem_addr[0]);
    assign accept = (state_q == StIdle) & op_ok & ~mis;
    assign mis_ev = (state_q == StIdle) & op_ok & mis;

    // Timeout fires on the BUSY cycle whose count reaches the limit; ack on that cycle wins.
    assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);
    assign bus_end = (state_q == StBusy) & (dport.ack | dport.err | tmo);
    assign fault   = dport.err | (~dport.ack & tmo);
    assign killed  = kill_q | mem_kill;

    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = mem_wdata;
        if (f_byte) begin
            sel_c   = 4'b0001 << mem_addr[1:0];
            wdata_c = {4{mem_wdata[7:0]}};
        end else if (f_hw) begin
            sel_c   = 4'b0011 << mem_addr[1:0];
            wdata_c = {2{mem_wdata[15:0]}};
        end
    end

    always_comb begin
        hw16 = dport.rdata[16*addr_q[1] +: 16];
        by8  = dport.rdata[8*addr_q[1:0] +: 8];
        if (word_q) begin
            ld_ext = dport.rdata;
        end else if (hw_q) begin
            ld_ext = {{16{~uns_q & hw16[15]}}, hw16};
        end else begin
            ld_ext = {{24{~uns_q & by8[7]}}, by8};
        end
    end

    always_comb begin
        state_d   = state_q;
        lsu_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    lsu_stall = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                lsu_stall = 1'b1;
                if (bus_end) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rst) lsu_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            kill_q     <= 1'b0;
            word_q     <= 1'b0;
            hw_q       <= 1'b0;
            uns_q      <= 1'b0;
            rdata_q    <= '0;
            bad_addr_q <= '0;
            done_q     <= 1'b0;
            ld_mis_q   <= 1'b0;
            st_mis_q   <= 1'b0;
            ld_flt_q   <= 1'b0;
            st_flt_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ld_mis_q <= 1'b0;
            st_mis_q <= 1'b0;
            ld_flt_q <= 1'b0;
            st_flt_q <= 1'b0;
            rdata_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        addr_q  <= mem_addr;
                        wdata_q <= wdata_c;
                        sel_q   <= sel_c;
                        we_q    <= f_wr;
                        word_q  <= f_word;
                        hw_q    <= f_hw;
                        uns_q   <= f_uns;
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        kill_q  <= 1'b0;
                    end
                    if (mis_ev) begin
                        ld_mis_q   <= f_rd;
                        st_mis_q   <= f_wr;
                        bad_addr_q <= mem_addr;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (mem_kill) kill_q <= 1'b1;
                    if (bus_end) begin
                        cyc_q <= 1'b0;
                        // A killed op still finishes its bus cycle but reports nothing.
                        if (!killed) begin
                            done_q <= 1'b1;
                            if (fault) begin
                                ld_flt_q   <= ~we_q;
                                st_flt_q   <= we_q;
                                bad_addr_q <= addr_q;
                            end else if (!we_q) begin
                                rdata_q <= ld_ext;
                            end
                        end
                    end
                end
                StDone:  kill_q <= 1'b0;
                default: kill_q <= 1'b0;
            endcase
        end
    end

    assign dport.addr  = {addr_q[31:2], 2'b00};
    assign dport.wdata = wdata_q;
    assign dport.sel   = sel_q;
    assign dport.we    = we_q;
    assign dport.cyc   = cyc_q;
    assign dport.stb   = cyc_q;

    assign lsu_rdata         = rdata_q;
    assign lsu_done          = done_q;
    assign lsu_ld_misaligned = ld_mis_q;
    assign lsu_st_misaligned = st_mis_q;
    assign lsu_ld_fault      = ld_flt_q;
    assign lsu_st_fault      = st_flt_q;
    assign lsu_bad_addr      = bad_addr_q;
endmodule

// File: tb/tb_titan_lsu.sv
// Directed bench for titan_lsu: a vector table of single-beat ops plus hand sequences for
// misalignment, no-op flags, kill and asynchronous reset.
module tb_titan_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_kill;
    logic [5:0]  mem_flags;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] lsu_rdata, lsu_bad_addr;
    logic        lsu_done, lsu_stall, lsu_ld_misaligned, lsu_st_misaligned;
    logic        lsu_ld_fault, lsu_st_fault;

    int total = 0;
    int bad   = 0;

    titan_lsu_if bus ();

    titan_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_flags         (mem_flags),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_kill          (mem_kill),
        .lsu_rdata         (lsu_rdata),
        .lsu_done          (lsu_done),
        .lsu_stall         (lsu_stall),
        .lsu_ld_misaligned (lsu_ld_misaligned),
        .lsu_st_misaligned (lsu_st_misaligned),
        .lsu_ld_fault      (lsu_ld_fault),
        .lsu_st_fault      (lsu_st_fault),
        .lsu_bad_addr      (lsu_bad_addr),
        .dport             (bus)
    );

    always #5 clk = ~clk;

    // flags: {wr, r, word, hw, byte, unsigned}
    localparam logic [5:0] LW  = 6'b011000;
    localparam logic [5:0] LH  = 6'b010100;
    localparam logic [5:0] LHU = 6'b010101;
    localparam logic [5:0] LB  = 6'b010010;
    localparam logic [5:0] LBU = 6'b010011;
    localparam logic [5:0] SW  = 6'b101000;
    localparam logic [5:0] SH  = 6'b100100;
    localparam logic [5:0] SB  = 6'b100010;

    typedef struct {
        string       name;
        logic [5:0]  flags;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_lat;   // BUSY cycle carrying ack; 0 = never (timeout)
        logic        err;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(string n, logic [5:0] f, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, int lat, logic e, logic [3:0] s,
                                logic [31:0] ewd, logic [31:0] erd, logic ef);
        vec_t v;
        v.name = n; v.flags = f; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_lat = lat;
        v.err = e; v.exp_sel = s; v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_fault = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic run_vec(input vec_t v);
        int  nbusy;
        logic is_wr;
        is_wr = v.flags[5];
        nbusy = (v.ack_lat == 0) ? 4 : v.ack_lat;
        step();
        mem_valid = 1'b1; mem_flags = v.flags; mem_addr = v.addr; mem_wdata = v.wdata;
        mid();
        check({v.name, " accept stall"}, lsu_stall, 1'b1);
        check({v.name, " accept cyc"}, bus.cyc, 1'b0);
        for (int k = 1; k <= nbusy; k++) begin
            step();
            bus.rdata = v.rdata;
            bus.ack   = (k == v.ack_lat);
            bus.err   = (k == v.ack_lat) & v.err;
            mid();
            check($sformatf("%s busy%0d cyc", v.name, k), bus.cyc, 1'b1);
            check($sformatf("%s busy%0d stall", v.name, k), lsu_stall, 1'b1);
            if (k == 1) begin
                check({v.name, " stb"}, bus.stb, 1'b1);
                check({v.name, " addr"}, bus.addr, {v.addr[31:2], 2'b00});
                check({v.name, " sel"}, bus.sel, v.exp_sel);
                check({v.name, " we"}, bus.we, is_wr);
                if (is_wr) check({v.name, " wdata"}, bus.wdata, v.exp_wdata);
            end
        end
        step();
        bus.ack = 1'b0; bus.err = 1'b0; mem_valid = 1'b0;
        mid();
        check({v.name, " done"}, lsu_done, 1'b1);
        check({v.name, " done stall"}, lsu_stall, 1'b0);
        check({v.name, " done cyc"}, bus.cyc, 1'b0);
        check({v.name, " rdata"}, lsu_rdata, v.exp_rdata);
        check({v.name, " ld_fault"}, lsu_ld_fault, v.exp_fault & ~is_wr);
        check({v.name, " st_fault"}, lsu_st_fault, v.exp_fault & is_wr);
        if (v.exp_fault) check({v.name, " bad_addr"}, lsu_bad_addr, v.addr);
        step();
        mid();
        check({v.name, " after done"}, lsu_done, 1'b0);
        check({v.name, " after fault"}, {31'd0, lsu_ld_fault | lsu_st_fault}, 32'd0);
    endtask

    // One-cycle op that must not start a bus cycle; optional misaligned pulse expected.
    task automatic run_nobus(input string name, input logic [5:0] f, input logic [31:0] a,
                             input logic kill, input logic exp_ldm, input logic exp_stm);
        step();
        mem_valid = 1'b1; mem_flags = f; mem_addr = a; mem_kill = kill;
        mid();
        check({name, " stall"}, lsu_stall, 1'b0);
        step();
        mem_valid = 1'b0; mem_kill = 1'b0;
        mid();
        check({name, " cyc"}, bus.cyc, 1'b0);
        check({name, " ld_mis"}, lsu_ld_misaligned, exp_ldm);
        check({name, " st_mis"}, lsu_st_misaligned, exp_stm);
        if (exp_ldm | exp_stm) check({name, " bad_addr"}, lsu_bad_addr, a);
        step();
        mid();
        check({name, " pulse end"}, {30'd0, lsu_ld_misaligned, lsu_st_misaligned}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_kill = 1'b0; mem_flags = '0;
        mem_addr = '0; mem_wdata = '0;
        bus.rdata = '0; bus.ack = 1'b0; bus.err = 1'b0;

        vecs[0]  = mk("lw",        LW,  32'h1000, 32'h0, 32'hDEADBEEF, 3, 1'b0, 4'b1111,
                      32'h0, 32'hDEADBEEF, 1'b0);
        vecs[1]  = mk("lb",        LB,  32'h2003, 32'h0, 32'h80FF0000, 1, 1'b0, 4'b1000,
                      32'h0, 32'hFFFFFF80, 1'b0);
        vecs[2]  = mk("lbu",       LBU, 32'h2003, 32'h0, 32'h80FF0000, 2, 1'b0, 4'b1000,
                      32'h0, 32'h00000080, 1'b0);
        vecs[3]  = mk("sh",        SH,  32'h3002, 32'h1234ABCD, 32'hFFFFFFFF, 1, 1'b0, 4'b1100,
                      32'hABCDABCD, 32'h0, 1'b0);
        vecs[4]  = mk("sw_err",    SW,  32'h5000, 32'hCAFEF00D, 32'h0, 2, 1'b1, 4'b1111,
                      32'hCAFEF00D, 32'h0, 1'b1);
        vecs[5]  = mk("lw_tmo",    LW,  32'h6000, 32'h0, 32'h11111111, 0, 1'b0, 4'b1111,
                      32'h0, 32'h0, 1'b1);
        vecs[6]  = mk("lw_at_lim", LW,  32'h7000, 32'h0, 32'h12345678, 4, 1'b0, 4'b1111,
                      32'h0, 32'h12345678, 1'b0);
        vecs[7]  = mk("lh",        LH,  32'h8002, 32'h0, 32'h80017FFF, 2, 1'b0, 4'b1100,
                      32'h0, 32'hFFFF8001, 1'b0);
        vecs[8]  = mk("lhu",       LHU, 32'h8000, 32'h0, 32'h1234F00D, 1, 1'b0, 4'b0011,
                      32'h0, 32'h0000F00D, 1'b0);
        vecs[9]  = mk("sb",        SB,  32'h9001, 32'h000000A5, 32'h0, 1, 1'b0, 4'b0010,
                      32'hA5A5A5A5, 32'h0, 1'b0);
        vecs[10] = mk("lb_pos",    LB,  32'hA001, 32'h0, 32'h00007F00, 3, 1'b0, 4'b0010,
                      32'h0, 32'h0000007F, 1'b0);

        #3;
        check("reset cyc", bus.cyc, 1'b0);
        check("reset stb", bus.stb, 1'b0);
        check("reset stall", lsu_stall, 1'b0);
        check("reset done", lsu_done, 1'b0);
        check("reset rdata", lsu_rdata, 32'h0);
        check("reset bad_addr", lsu_bad_addr, 32'h0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        run_nobus("lw_mis",   LW, 32'h4001, 1'b0, 1'b1, 1'b0);
        run_nobus("sh_mis",   SH, 32'h3001, 1'b0, 1'b0, 1'b1);
        run_nobus("wr_and_r", 6'b111000, 32'h1000, 1'b0, 1'b0, 1'b0);
        run_nobus("two_size", 6'b010110, 32'h1000, 1'b0, 1'b0, 1'b0);
        run_nobus("idle_kill", LW, 32'h1000, 1'b1, 1'b0, 1'b0);

        // Kill during BUSY: bus cycle runs to ack, no completion reported.
        step();
        mem_valid = 1'b1; mem_flags = LW; mem_addr = 32'hB000;
        for (int k = 1; k <= 4; k++) begin
            step();
            mem_kill = (k == 1);
            bus.ack  = (k == 4);
            bus.rdata = 32'h55AA55AA;
            mid();
            check($sformatf("kill busy%0d cyc", k), bus.cyc, 1'b1);
            check($sformatf("kill busy%0d stall", k), lsu_stall, 1'b1);
        end
        step();
        bus.ack = 1'b0; mem_valid = 1'b0; mem_kill = 1'b0;
        mid();
        check("kill done", lsu_done, 1'b0);
        check("kill fault", {30'd0, lsu_ld_fault, lsu_st_fault}, 32'd0);
        check("kill cyc", bus.cyc, 1'b0);
        run_vec(vecs[0]);

        // Asynchronous reset mid-BUSY.
        step();
        mem_valid = 1'b1; mem_flags = LW; mem_addr = 32'hC000;
        step();
        mid();
        check("pre-rst cyc", bus.cyc, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("rst cyc", bus.cyc, 1'b0);
        check("rst stb", bus.stb, 1'b0);
        check("rst stall", lsu_stall, 1'b0);
        step();
        mem_valid = 1'b0;
        rst = 1'b0;
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
